// File: rtl/ast_pwr_pkg.sv
// Shared types and constants for the AST remote power sequencer.
// Defaults assume the 32.768 kHz clock.
package ast_pwr_pkg;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_WAIT_OK  = 3'd1,
        ST_ON       = 3'd2,
        ST_RESET    = 3'd3,
        ST_SHUTDOWN = 3'd4,
        ST_FAULT    = 3'd5,
        ST_RETRY    = 3'd6
    } pwr_state_e;

    localparam int unsigned TMR_W         = 18;
    localparam int unsigned DEF_DEB_CYC   = 32;
    localparam int unsigned DEF_PWROK_TMO = 16384;
    localparam int unsigned DEF_RST_PULSE = 3277;
    localparam int unsigned DEF_OFF_TMO   = 131072;
    localparam int unsigned DEF_RETRY_GAP = 32768;

    // Timer value seen on the last cycle of a dwell of 'cyc' cycles.
    function automatic logic [TMR_W-1:0] tmr_last(input int unsigned cyc);
        return TMR_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/ast_pwr_seq_if.sv
// Request / PSU / system-reset bundle between the remote-control front end and ast_pwr_seq.
interface ast_pwr_seq_if;
    logic       i_ast_pson;
    logic       i_ast_pwroff;
    logic       i_ast_reset;
    logic       i_psu_pwrok;
    logic       o_psu_on;
    logic       o_sys_rst_n;
    logic       o_pwr_fault;
    logic [2:0] o_state;

    modport master (
        output i_ast_pson, i_ast_pwroff, i_ast_reset, i_psu_pwrok,
        input  o_psu_on, o_sys_rst_n, o_pwr_fault, o_state
    );

    modport slave (
        input  i_ast_pson, i_ast_pwroff, i_ast_reset, i_psu_pwrok,
        output o_psu_on, o_sys_rst_n, o_pwr_fault, o_state
    );
endinterface

// File: rtl/ast_req_qual.sv
// Request qualifier: one registered pulse once a level has been high for DEB_CYC
// consecutive cycles; the count saturates so a held request fires only once.
module ast_req_qual
    import ast_pwr_pkg::*;
#(
    parameter int unsigned DEB_CYC = DEF_DEB_CYC
) (
    input  logic i_clk_32k,
    input  logic i_rst_n,
    input  logic req_i,
    output logic pulse_o
);
    localparam int unsigned     CNT_W   = $clog2(DEB_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYC);
    localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(DEB_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    always_comb begin
        cnt_d = '0;
        if (req_i) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
        pulse_d = req_i && (cnt_q == CNT_ARM);
    end

    always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;
endmodule

// File: rtl/ast_pwr_seq.sv
// Remote power sequencer: drives PS_ON and system reset, supervises PWROK with timeouts.
// Define AST_PWR_RETRY_EN to retry once after a PWROK timeout before declaring a fault.
module ast_pwr_seq
    import ast_pwr_pkg::*;
#(
    parameter int unsigned DEB_CYC   = DEF_DEB_CYC,
    parameter int unsigned PWROK_TMO = DEF_PWROK_TMO,
    parameter int unsigned RST_PULSE = DEF_RST_PULSE,
`ifdef AST_PWR_RETRY_EN
    parameter int unsigned RETRY_GAP = DEF_RETRY_GAP,
`endif
    parameter int unsigned OFF_TMO   = DEF_OFF_TMO
) (
    input logic         i_clk_32k,
    input logic         i_rst_n,
    ast_pwr_seq_if.slave bus
);
    logic pson_p, pwroff_p, reset_p;
    logic pwrok_meta_q, pwrok_s_q;
    pwr_state_e       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic psu_on_q, psu_on_d, rst_n_q, rst_n_d, fault_q, fault_d;
`ifdef AST_PWR_RETRY_EN
    logic retry_q, retry_d;
`endif

    ast_req_qual #(.DEB_CYC(DEB_CYC)) u_qual_pson (
        .i_clk_32k(i_clk_32k), .i_rst_n(i_rst_n), .req_i(bus.i_ast_pson),   .pulse_o(pson_p));
    ast_req_qual #(.DEB_CYC(DEB_CYC)) u_qual_pwroff (
        .i_clk_32k(i_clk_32k), .i_rst_n(i_rst_n), .req_i(bus.i_ast_pwroff), .pulse_o(pwroff_p));
    ast_req_qual #(.DEB_CYC(DEB_CYC)) u_qual_reset (
        .i_clk_32k(i_clk_32k), .i_rst_n(i_rst_n), .req_i(bus.i_ast_reset),  .pulse_o(reset_p));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF:     if (pson_p) state_d = ST_WAIT_OK;
            ST_WAIT_OK: begin
                if (pwrok_s_q) begin
                    state_d = ST_ON;
                end else if (tmr_q == tmr_last(PWROK_TMO)) begin
`ifdef AST_PWR_RETRY_EN
                    state_d = retry_q ? ST_FAULT : ST_RETRY;
`else
                    state_d = ST_FAULT;
`endif
                end else if (pwroff_p) begin
                    state_d = ST_SHUTDOWN;
                end
            end
            // Losing PWROK outranks any request while the PSU is meant to be up.
            ST_ON: begin
                if (!pwrok_s_q)    state_d = ST_FAULT;
                else if (pwroff_p) state_d = ST_SHUTDOWN;
                else if (reset_p)  state_d = ST_RESET;
            end
            ST_RESET: begin
                if (!pwrok_s_q)                          state_d = ST_FAULT;
                else if (pwroff_p)                       state_d = ST_SHUTDOWN;
                else if (tmr_q == tmr_last(RST_PULSE))   state_d = ST_ON;
            end
            ST_SHUTDOWN: begin
                if (!pwrok_s_q)                          state_d = ST_OFF;
                else if (tmr_q == tmr_last(OFF_TMO))     state_d = ST_FAULT;
            end
            ST_FAULT:   if (pwroff_p) state_d = ST_OFF;
`ifdef AST_PWR_RETRY_EN
            ST_RETRY: begin
                if (pwroff_p)                            state_d = ST_OFF;
                else if (tmr_q == tmr_last(RETRY_GAP))   state_d = ST_WAIT_OK;
            end
`endif
            default:    state_d = ST_OFF;
        endcase
    end

    always_comb begin
        tmr_d = '0;
        if (state_d == state_q) begin
            tmr_d = (&tmr_q) ? tmr_q : tmr_q + 1'b1;
        end
    end

`ifdef AST_PWR_RETRY_EN
    always_comb begin
        retry_d = retry_q;
        if (state_q == ST_OFF || state_q == ST_ON) begin
            retry_d = 1'b0;
        end else if (state_d == ST_RETRY && state_q != ST_RETRY) begin
            retry_d = 1'b1;
        end
    end
`endif

    // Outputs are decoded from the next state so they register together with it.
    always_comb begin
        psu_on_d = 1'b0;
        rst_n_d  = 1'b0;
        fault_d  = 1'b0;
        case (state_d)
            ST_WAIT_OK, ST_RESET: psu_on_d = 1'b1;
            ST_ON: begin
                psu_on_d = 1'b1;
                rst_n_d  = 1'b1;
            end
            ST_FAULT: fault_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pwrok_meta_q <= 1'b0;
            pwrok_s_q    <= 1'b0;
            state_q      <= ST_OFF;
            tmr_q        <= '0;
            psu_on_q     <= 1'b0;
            rst_n_q      <= 1'b0;
            fault_q      <= 1'b0;
`ifdef AST_PWR_RETRY_EN
            retry_q      <= 1'b0;
`endif
        end else begin
            pwrok_meta_q <= bus.i_psu_pwrok;
            pwrok_s_q    <= pwrok_meta_q;
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            psu_on_q     <= psu_on_d;
            rst_n_q      <= rst_n_d;
            fault_q      <= fault_d;
`ifdef AST_PWR_RETRY_EN
            retry_q      <= retry_d;
`endif
        end
    end

    assign bus.o_psu_on    = psu_on_q;
    assign bus.o_sys_rst_n = rst_n_q;
    assign bus.o_pwr_fault = fault_q;
    assign bus.o_state     = state_q;
endmodule

// File: tb/tb_ast_pwr_seq.sv
// Bench for ast_pwr_seq: directed scenarios plus a random phase, all checked against a
// cycle-level reference model of the sequencing rules.
`timescale 1ns/1ps
module tb_ast_pwr_seq;
    localparam int DEB = 4, PTMO = 64, RPUL = 16, OTMO = 128, RGAP = 32;
    localparam int TMAX = 262143;
`ifdef AST_PWR_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ast_pwr_seq_if bus();

    ast_pwr_seq #(
        .DEB_CYC(DEB), .PWROK_TMO(PTMO), .RST_PULSE(RPUL),
`ifdef AST_PWR_RETRY_EN
        .RETRY_GAP(RGAP),
`endif
        .OFF_TMO(OTMO)
    ) dut (
        .i_clk_32k(clk),
        .i_rst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: states 0 OFF,1 WAIT_OK,2 ON,3 RESET,4 SHUTDOWN,5 FAULT,6 RETRY.
    int   m_state, m_dwell, m_nxt;
    int   m_run [3];
    bit   m_pulse [3];
    bit   m_ok1, m_ok2, m_retry;
    logic [2:0] req_v;
    assign req_v = {bus.i_ast_reset, bus.i_ast_pwroff, bus.i_ast_pson};

    function automatic int next_state(int s, int dw, bit ok, bit pon, bit poff, bit prst, bit rty);
        int el = dw + 1;
        case (s)
            0: return pon ? 1 : 0;
            1: begin
                if (ok) return 2;
                if (el == PTMO) return (RETRY_EN && !rty) ? 6 : 5;
                if (poff) return 4;
                return 1;
            end
            2: begin
                if (!ok) return 5;
                if (poff) return 4;
                if (prst) return 3;
                return 2;
            end
            3: begin
                if (!ok) return 5;
                if (poff) return 4;
                if (el == RPUL) return 2;
                return 3;
            end
            4: begin
                if (!ok) return 0;
                if (el == OTMO) return 5;
                return 4;
            end
            5: return poff ? 0 : 5;
            6: begin
                if (poff) return 0;
                if (el == RGAP) return 1;
                return 6;
            end
            default: return 0;
        endcase
    endfunction

    // {psu_on, sys_rst_n, fault} for a model state
    function automatic logic [2:0] outs_of(int s);
        case (s)
            1, 3:    return 3'b100;
            2:       return 3'b110;
            5:       return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    always_comb m_nxt = next_state(m_state, m_dwell, m_ok2, m_pulse[0], m_pulse[1], m_pulse[2], m_retry);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 0;
            m_dwell <= 0;
            m_ok1   <= 1'b0;
            m_ok2   <= 1'b0;
            m_retry <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                m_run[k]   <= 0;
                m_pulse[k] <= 1'b0;
            end
        end else begin
            m_ok1   <= bus.i_psu_pwrok;
            m_ok2   <= m_ok1;
            m_state <= m_nxt;
            m_dwell <= (m_nxt != m_state) ? 0 : ((m_dwell < TMAX) ? m_dwell + 1 : TMAX);
            if (m_state == 0 || m_state == 2) m_retry <= 1'b0;
            else if (m_nxt == 6 && m_state != 6) m_retry <= 1'b1;
            for (int k = 0; k < 3; k++) begin
                m_pulse[k] <= req_v[k] && (m_run[k] == DEB - 1);
                m_run[k]   <= req_v[k] ? ((m_run[k] < DEB) ? m_run[k] + 1 : DEB) : 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cmp_model();
        logic [2:0] e;
        e = outs_of(m_state);
        chk("m_state",  {29'd0, bus.o_state},     m_state);
        chk("m_psu_on", {31'd0, bus.o_psu_on},    {31'd0, e[2]});
        chk("m_rst_n",  {31'd0, bus.o_sys_rst_n}, {31'd0, e[1]});
        chk("m_fault",  {31'd0, bus.o_pwr_fault}, {31'd0, e[0]});
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            cmp_model();
        end
    endtask

    int h, lo, psu_drop, saw_rst;

    initial begin
        bus.i_ast_pson   = 1'b0;
        bus.i_ast_pwroff = 1'b0;
        bus.i_ast_reset  = 1'b0;
        bus.i_psu_pwrok  = 1'b0;
        #23;
        chk("rst_state", {29'd0, bus.o_state},     0);
        chk("rst_psu",   {31'd0, bus.o_psu_on},    0);
        chk("rst_rstn",  {31'd0, bus.o_sys_rst_n}, 0);
        chk("rst_fault", {31'd0, bus.o_pwr_fault}, 0);
        @(negedge clk) rst_n = 1'b1;
        tick(3);

        // glitch shorter than the qualifier window
        h = $urandom_range(1, DEB - 1);
        bus.i_ast_pson = 1'b1;
        tick(h);
        bus.i_ast_pson = 1'b0;
        tick(10);
        chk("glitch_state", {29'd0, bus.o_state},  0);
        chk("glitch_psu",   {31'd0, bus.o_psu_on}, 0);

        // normal power-on
        bus.i_ast_pson = 1'b1;
        tick(4);
        chk("pon_c4_psu", {31'd0, bus.o_psu_on}, 0);
        tick(1);
        chk("pon_c5_psu",   {31'd0, bus.o_psu_on}, 1);
        chk("pon_c5_state", {29'd0, bus.o_state},  1);
        tick(20);
        bus.i_psu_pwrok = 1'b1;
        tick(2);
        chk("ok_c2_rstn", {31'd0, bus.o_sys_rst_n}, 0);
        tick(1);
        chk("ok_c3_state", {29'd0, bus.o_state},     2);
        chk("ok_c3_rstn",  {31'd0, bus.o_sys_rst_n}, 1);
        tick(30);
        chk("pson_hold_state", {29'd0, bus.o_state}, 2);
        bus.i_ast_pson = 1'b0;
        tick(2);

        // remote reset while ON
        h = $urandom_range(DEB, 15);
        lo = 0; psu_drop = 0;
        bus.i_ast_reset = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (c == h) bus.i_ast_reset = 1'b0;
            tick(1);
            if (bus.o_sys_rst_n === 1'b0) lo++;
            if (bus.o_psu_on !== 1'b1) psu_drop++;
        end
        chk("rst_low_width", lo, RPUL);
        chk("rst_psu_kept",  psu_drop, 0);
        chk("rst_back_on",   {29'd0, bus.o_state}, 2);

        // pwroff and reset together: pwroff wins
        saw_rst = 0;
        bus.i_ast_pwroff = 1'b1;
        bus.i_ast_reset  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            if (bus.o_state === 3'd3) saw_rst++;
        end
        chk("sim_state",  {29'd0, bus.o_state},  4);
        chk("sim_psu",    {31'd0, bus.o_psu_on}, 0);
        chk("sim_no_rst", saw_rst, 0);
        bus.i_ast_pwroff = 1'b0;
        bus.i_ast_reset  = 1'b0;
        bus.i_psu_pwrok  = 1'b0;
        tick(2);
        chk("sd_c2_state", {29'd0, bus.o_state}, 4);
        tick(1);
        chk("sd_c3_state", {29'd0, bus.o_state}, 0);

        // PWROK timeout
        bus.i_ast_pson = 1'b1;
        tick(5);
        chk("tmo_wait", {29'd0, bus.o_state}, 1);
        bus.i_ast_pson = 1'b0;
        tick(63);
        chk("tmo_c63", {29'd0, bus.o_state}, 1);
        tick(1);
`ifdef AST_PWR_RETRY_EN
        chk("tmo_retry", {29'd0, bus.o_state}, 6);
        tick(31);
        chk("retry_c31", {29'd0, bus.o_state}, 6);
        tick(1);
        chk("retry_back", {29'd0, bus.o_state}, 1);
        tick(63);
        chk("tmo2_c63", {29'd0, bus.o_state}, 1);
        tick(1);
`endif
        chk("tmo_fault_state", {29'd0, bus.o_state},     5);
        chk("tmo_fault_psu",   {31'd0, bus.o_psu_on},    0);
        chk("tmo_fault_flag",  {31'd0, bus.o_pwr_fault}, 1);
        bus.i_ast_pwroff = 1'b1;
        tick(5);
        chk("clr_state", {29'd0, bus.o_state},     0);
        chk("clr_fault", {31'd0, bus.o_pwr_fault}, 0);
        bus.i_ast_pwroff = 1'b0;
        tick(2);

        // shutdown with PWROK stuck high
        bus.i_ast_pson = 1'b1;
        tick(5);
        bus.i_psu_pwrok = 1'b1;
        tick(3);
        chk("sd2_on", {29'd0, bus.o_state}, 2);
        bus.i_ast_pson   = 1'b0;
        bus.i_ast_pwroff = 1'b1;
        tick(5);
        chk("sd2_enter", {29'd0, bus.o_state}, 4);
        bus.i_ast_pwroff = 1'b0;
        tick(127);
        chk("sd2_c127", {29'd0, bus.o_state}, 4);
        tick(1);
        chk("sd2_fault", {29'd0, bus.o_state},  5);
        chk("sd2_psu",   {31'd0, bus.o_psu_on}, 0);
        bus.i_ast_pwroff = 1'b1;
        tick(5);
        bus.i_ast_pwroff = 1'b0;
        bus.i_psu_pwrok  = 1'b0;
        tick(3);

        // async reset in the middle of a remote reset pulse
        bus.i_ast_pson = 1'b1;
        tick(5);
        bus.i_psu_pwrok = 1'b1;
        tick(3);
        bus.i_ast_pson  = 1'b0;
        bus.i_ast_reset = 1'b1;
        tick(5);
        chk("ar_in_reset", {29'd0, bus.o_state}, 3);
        tick(4);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_state", {29'd0, bus.o_state},     0);
        chk("ar_psu",   {31'd0, bus.o_psu_on},    0);
        chk("ar_rstn",  {31'd0, bus.o_sys_rst_n}, 0);
        chk("ar_fault", {31'd0, bus.o_pwr_fault}, 0);
        @(negedge clk);
        bus.i_ast_reset = 1'b0;
        bus.i_psu_pwrok = 1'b0;
        rst_n = 1'b1;
        tick(3);
        chk("ar_after", {29'd0, bus.o_state}, 0);

        // random phase against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0)  bus.i_ast_pson   = ~bus.i_ast_pson;
            if ($urandom_range(0, 11) == 0) bus.i_ast_pwroff = ~bus.i_ast_pwroff;
            if ($urandom_range(0, 9) == 0)  bus.i_ast_reset  = ~bus.i_ast_reset;
            if (bus.o_psu_on && !bus.i_psu_pwrok && $urandom_range(0, 19) == 0)
                bus.i_psu_pwrok = 1'b1;
            else if (!bus.o_psu_on && bus.i_psu_pwrok && $urandom_range(0, 7) == 0)
                bus.i_psu_pwrok = 1'b0;
            else if (bus.i_psu_pwrok && $urandom_range(0, 399) == 0)
                bus.i_psu_pwrok = 1'b0;
            tick(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ast_pwr_seq.md
# ast_pwr_seq

Remote power sequencer that sits directly downstream of the remote-control input synchroniser. It consumes the synchronised, activity-gated AST power-on, power-off and reset request levels and drives the PSU PS_ON line and the system reset. It supervises PSU PWROK with timeouts and reports faults.

## Interface
Parameters:
- DEB_CYC, 32: consecutive high cycles before a request is qualified (~1 ms).
- PWROK_TMO, 16384: maximum WAIT_OK dwell before fault (~0.5 s).
- RST_PULSE, 3277: o_sys_rst_n low width for a remote reset (~100 ms).
- OFF_TMO, 131072: maximum SHUTDOWN dwell waiting for PWROK low (~4 s).
- RETRY_GAP, 32768: off time before the automatic retry (~1 s, AST_PWR_RETRY_EN only).

Ports:
- i_clk_32k  in  1  32.768 kHz clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_ast_pson  in  1  power-on request level, active high, already synchronised.
- i_ast_pwroff  in  1  power-off request level, active high, already synchronised.
- i_ast_reset  in  1  reset request level, active high, already synchronised.
- i_psu_pwrok  in  1  PSU power-good, asynchronous; synchronised internally with 2 flops.
- o_psu_on  out  1  PS_ON control, high = PSU on.
- o_sys_rst_n  out  1  system reset, active low.
- o_pwr_fault  out  1  sticky fault flag.
- o_state  out  3  current state encoding, for debug.

## Operation
- Each request input passes through a qualifier. The qualifier counts consecutive high cycles, saturating at DEB_CYC. It emits a one-cycle pulse when the count reaches DEB_CYC. A low input clears the count. A request held high produces exactly one pulse.
- Priority among same-cycle pulses: pwroff > reset > pson.
- States and outputs, all registered:
  - OFF=0: psu_on=0, rst_n=0.
  - WAIT_OK=1: psu_on=1, rst_n=0.
  - ON=2: psu_on=1, rst_n=1.
  - RESET=3: psu_on=1, rst_n=0.
  - SHUTDOWN=4: psu_on=0, rst_n=0.
  - FAULT=5: psu_on=0, rst_n=0, fault=1.
  - RETRY=6: psu_on=0, rst_n=0.
- Transitions:
  - OFF: pson pulse → WAIT_OK. Reset and pwroff pulses are ignored.
  - WAIT_OK: pwrok_s high → ON. Timer reaches PWROK_TMO → FAULT. pwroff pulse → SHUTDOWN.
  - ON: pwrok_s low → FAULT. pwroff pulse → SHUTDOWN. reset pulse → RESET. pson pulse is ignored.
  - RESET: after RST_PULSE cycles → ON. pwroff pulse → SHUTDOWN (aborts the pulse). pwrok_s low → FAULT.
  - SHUTDOWN: pwrok_s low → OFF. Timer reaches OFF_TMO → FAULT (psu_on stays 0).
  - FAULT: pwroff pulse → OFF and clears o_pwr_fault. All other requests are ignored.
- A single 18-bit state timer clears on every state change and saturates at its maximum value.
- Reset mid-operation: all outputs return to reset values asynchronously. PSU turns off immediately.

## Timing
- Reset values: o_psu_on=0, o_sys_rst_n=0, o_pwr_fault=0, o_state=0 (OFF). Qualifier counts and timer are 0.
- Request latency: input rises at edge 0 → qualified pulse at edge DEB_CYC → state and outputs update at edge DEB_CYC+1.
- A PWROK edge reaches the FSM 2 cycles after sampling. The state change occurs on the following edge.
- RESET dwell is exactly RST_PULSE cycles. o_sys_rst_n is low for RST_PULSE cycles.
- Timeouts fire on the edge where the timer equals the limit minus 1, giving exactly the limit in cycles of dwell.

## Configuration
- AST_PWR_RETRY_EN defined:
  - A PWROK_TMO timeout in WAIT_OK with the retry flag clear → RETRY, and the retry flag is set.
  - After RETRY_GAP cycles, RETRY → WAIT_OK.
  - A second timeout → FAULT.
  - The retry flag clears in OFF and ON.
  - A pwroff pulse in RETRY → OFF.
- AST_PWR_RETRY_EN undefined: the RETRY state and flag are absent, and every timeout goes directly to FAULT. Encoding 6 is unused.

## Structure
- Package ast_pwr_pkg:
  - State enumeration values 0–6.
  - Default cycle constants.
  - Timer width constant TMR_W=18.
- Sub-module ast_req_qual:
  - Debounce counter plus rising-detect pulse, parameterised by DEB_CYC.
  - Instantiated three times (pson, pwroff, reset).

## Test plan
Use DEB_CYC=4, PWROK_TMO=64, RST_PULSE=16, OFF_TMO=128, RETRY_GAP=32.
- Normal power-on:
  - pson high, PWROK rises 20 cycles after o_psu_on → o_psu_on=1 at cycle 5.
  - ON is reached and o_sys_rst_n=1 three cycles after PWROK.
  - Holding pson high causes no further action.
- Glitch rejection: pson high for 3 cycles, then low → state stays OFF, o_psu_on=0.
- Remote reset in ON: reset held 10 cycles → o_sys_rst_n low for exactly 16 cycles, then ON. o_psu_on stays 1 throughout.
- PWROK timeout:
  - Without the macro: no PWROK → FAULT after 64 cycles, with o_psu_on=0 and o_pwr_fault=1.
  - A pwroff pulse then clears to OFF.
  - With the macro: RETRY for 32 cycles, then WAIT_OK again, then FAULT.
- Simultaneous pwroff and reset in ON: both rise together → SHUTDOWN, o_psu_on=0. PWROK drop → OFF. No reset pulse occurs.
- Async reset asserted in ON mid-RESET → all outputs are at reset values immediately. After release, state is OFF.
